// File: rtl/bn254_host_link.sv
// Host-side sequencer for the BN254 core: streams words into core BRAM, starts
// the core, waits for it to finish, then streams results back out via a small FIFO.
module bn254_host_link #(
   parameter int DATA_W   = 436,
   parameter int ADDR_W   = 10,
   parameter int RD_LAT   = 2,
   parameter int START_TO = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_func,
   input  logic [ADDR_W-1:0] cmd_ld_base,
   input  logic [ADDR_W-1:0] cmd_ld_len,
   input  logic [ADDR_W-1:0] cmd_st_base,
   input  logic [ADDR_W-1:0] cmd_st_len,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              done,
   output logic              err,
   output logic              core_run,
   output logic [3:0]        core_n_func,
   output logic              core_extin_en,
   output logic [ADDR_W-1:0] core_extin_addr,
   output logic [DATA_W-1:0] core_extin_data,
   output logic [ADDR_W-1:0] core_extout_addr,
   input  logic [DATA_W-1:0] core_extout_data,
   input  logic              core_busy
);

   localparam int DEPTH = RD_LAT + 2;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TW    = $clog2(START_TO + 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, START, WAIT_HI, WAIT_LO, UNLOAD, DRAIN
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        func_q, func_d;
   logic [ADDR_W-1:0] ld_base_q, ld_base_d, ld_len_q, ld_len_d;
   logic [ADDR_W-1:0] st_base_q, st_base_d, st_len_q, st_len_d;
   logic [ADDR_W-1:0] ld_cnt_q, ld_cnt_d, st_cnt_q, st_cnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              err_q, err_d;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [CW-1:0]     inflight_q, inflight_d, count_q, count_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0] fifo_mem [DEPTH];

   logic          issue, capture, pop, can_issue;
   logic [CW:0]   credit_used;

   always_comb begin
      state_d       = state_q;
      func_d        = func_q;
      ld_base_d     = ld_base_q;
      ld_len_d      = ld_len_q;
      st_base_d     = st_base_q;
      st_len_d      = st_len_q;
      ld_cnt_d      = ld_cnt_q;
      st_cnt_d      = st_cnt_q;
      timer_d       = timer_q;
      err_d         = err_q;
      cmd_ready     = 1'b0;
      s_ready       = 1'b0;
      core_run      = 1'b0;
      core_extin_en = 1'b0;
      done          = 1'b0;
      issue         = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               func_d    = cmd_func;
               ld_base_d = cmd_ld_base;
               ld_len_d  = cmd_ld_len;
               st_base_d = cmd_st_base;
               st_len_d  = cmd_st_len;
               ld_cnt_d  = '0;
               st_cnt_d  = '0;
               err_d     = 1'b0;
               state_d   = (cmd_ld_len == '0) ? START : LOAD;
            end
         end
         LOAD: begin
            s_ready = 1'b1;
            if (s_valid) begin
               core_extin_en = 1'b1;
               ld_cnt_d      = ld_cnt_q + ADDR_W'(1);
               if (ld_cnt_q == ld_len_q - ADDR_W'(1)) state_d = START;
            end
         end
         START: begin
            core_run = 1'b1;
            timer_d  = '0;
            state_d  = WAIT_HI;
         end
         WAIT_HI: begin
            if (core_busy) begin
               state_d = WAIT_LO;
            end else if (timer_q == TW'(START_TO - 1)) begin
               err_d   = 1'b1;
               done    = 1'b1;
               state_d = IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         WAIT_LO: begin
            if (!core_busy) begin
               if (st_len_q == '0) begin
                  done    = 1'b1;
                  state_d = IDLE;
               end else begin
                  state_d = UNLOAD;
               end
            end
         end
         UNLOAD: begin
            // A read is only issued when a FIFO slot is guaranteed for its data.
            if (can_issue) begin
               issue    = 1'b1;
               st_cnt_d = st_cnt_q + ADDR_W'(1);
               if (st_cnt_q == st_len_q - ADDR_W'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight_q == '0 && count_q == '0) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      capture     = vld_q[RD_LAT-1];
      pop         = (count_q != '0) && m_ready;
      credit_used = {1'b0, count_q} + {1'b0, inflight_q};
      can_issue   = credit_used < (CW+1)'(DEPTH);
      vld_d       = RD_LAT'({vld_q, issue});
      inflight_d  = inflight_q + CW'(issue) - CW'(capture);
      count_d     = count_q + CW'(capture) - CW'(pop);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (capture) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         func_q     <= '0;
         ld_base_q  <= '0;
         ld_len_q   <= '0;
         st_base_q  <= '0;
         st_len_q   <= '0;
         ld_cnt_q   <= '0;
         st_cnt_q   <= '0;
         timer_q    <= '0;
         err_q      <= 1'b0;
         vld_q      <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         func_q     <= func_d;
         ld_base_q  <= ld_base_d;
         ld_len_q   <= ld_len_d;
         st_base_q  <= st_base_d;
         st_len_q   <= st_len_d;
         ld_cnt_q   <= ld_cnt_d;
         st_cnt_q   <= st_cnt_d;
         timer_q    <= timer_d;
         err_q      <= err_d;
         vld_q      <= vld_d;
         inflight_q <= inflight_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // FIFO storage carries no reset; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (capture) fifo_mem[wr_ptr_q] <= core_extout_data;
   end

   assign m_valid          = (count_q != '0);
   assign m_data           = fifo_mem[rd_ptr_q];
   assign err              = err_q;
   assign core_n_func      = func_q;
   assign core_extin_addr  = ld_base_q + ld_cnt_q;
   assign core_extin_data  = s_data;
   assign core_extout_addr = st_base_q + st_cnt_q;

endmodule

// File: tb/tb_bn254_host_link.sv
// Self-checking bench for bn254_host_link with a behavioural core model and
// scoreboard queues for BRAM writes and result words.
module tb_bn254_host_link;

   localparam int DATA_W   = 436;
   localparam int ADDR_W   = 10;
   localparam int RD_LAT   = 2;
   localparam int START_TO = 64;
   localparam int MEM_N    = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid, cmd_ready;
   logic [3:0]        cmd_func;
   logic [ADDR_W-1:0] cmd_ld_base, cmd_ld_len, cmd_st_base, cmd_st_len;
   logic              s_valid, s_ready;
   logic [DATA_W-1:0] s_data;
   logic              m_valid, m_ready;
   logic [DATA_W-1:0] m_data;
   logic              done, err;
   logic              core_run;
   logic [3:0]        core_n_func;
   logic              core_extin_en;
   logic [ADDR_W-1:0] core_extin_addr, core_extout_addr;
   logic [DATA_W-1:0] core_extin_data, core_extout_data;
   logic              core_busy;

   always #5 clk = ~clk;

   bn254_host_link #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .START_TO(START_TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func),
      .cmd_ld_base(cmd_ld_base), .cmd_ld_len(cmd_ld_len),
      .cmd_st_base(cmd_st_base), .cmd_st_len(cmd_st_len),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .done(done), .err(err),
      .core_run(core_run), .core_n_func(core_n_func),
      .core_extin_en(core_extin_en), .core_extin_addr(core_extin_addr),
      .core_extin_data(core_extin_data), .core_extout_addr(core_extout_addr),
      .core_extout_data(core_extout_data), .core_busy(core_busy)
   );

   function automatic logic [DATA_W-1:0] pat(input int a);
      logic [108:0] w;
      w = {77'(a * 3 + 1), 32'(a ^ 32'h5A5A5A5A)};
      return {w, ~w, w ^ 109'(a), 109'(a)};
   endfunction

   function automatic logic [DATA_W-1:0] rnd_word();
      logic [DATA_W-1:0] w;
      w = '0;
      for (int i = 0; i < 14; i++) w = {w[DATA_W-33:0], 32'($urandom)};
      return w;
   endfunction

   // Core model: BRAM, RD_LAT read pipeline, busy window after each run pulse
   logic [DATA_W-1:0] core_mem [MEM_N];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];
   logic preload = 1'b0;
   int   busy_t = -1;
   int   busy_delay = 2, busy_len = 5;
   bit   never_busy = 1'b0;

   always @(posedge clk) begin
      if (preload) for (int i = 0; i < MEM_N; i++) core_mem[i] <= pat(i);
      else if (core_extin_en) core_mem[core_extin_addr] <= core_extin_data;
      rd_pipe[0] <= core_mem[core_extout_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (core_run && !never_busy) busy_t <= 0;
      else if (busy_t >= busy_delay + busy_len) busy_t <= -1;
      else if (busy_t >= 0) busy_t <= busy_t + 1;
   end
   assign core_extout_data = rd_pipe[RD_LAT-1];
   assign core_busy = (busy_t >= busy_delay) && (busy_t < busy_delay + busy_len);

   // Observation side of the scoreboard
   typedef struct {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } wr_t;
   wr_t               wr_seen[$], wr_exp[$];
   logic [DATA_W-1:0] md_seen[$], md_exp[$];
   logic [DATA_W-1:0] exp_mem [MEM_N];
   int   cyc = 0;
   int   done_cnt = 0, done_cyc = 0, run_cnt = 0, run_cyc = 0, accept_cyc = 0;
   int   fall_cyc = 0, beat_cyc = 0, sready_cyc = 0, mvalid_cyc = 0;
   logic [3:0] run_func = '0;
   logic busy_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (core_extin_en) wr_seen.push_back('{core_extin_addr, core_extin_data});
         if (m_valid && m_ready) begin md_seen.push_back(m_data); beat_cyc = cyc; end
         if (core_run) begin run_cnt++; run_cyc = cyc; run_func = core_n_func; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (cmd_valid && cmd_ready) accept_cyc = cyc;
         if (busy_prev && !core_busy) fall_cyc = cyc;
         if (s_ready) sready_cyc++;
         if (m_valid) mvalid_cyc++;
      end
      busy_prev = core_busy;
   end

   int n_cmp = 0, n_mis = 0;
   bit rand_ready = 1'b0;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic issue_cmd(input logic [3:0] f, input int ldb, input int ldl,
                            input int stb, input int stl);
      int t = 0;
      while (!cmd_ready && t < 500) begin step(1); t++; end
      cmd_valid = 1'b1; cmd_func = f;
      cmd_ld_base = ADDR_W'(ldb); cmd_ld_len = ADDR_W'(ldl);
      cmd_st_base = ADDR_W'(stb); cmd_st_len = ADDR_W'(stl);
      step(1);
      cmd_valid = 1'b0;
   endtask

   task automatic send_words(input int ldb, input int n);
      logic [DATA_W-1:0] w;
      logic [ADDR_W-1:0] a;
      int t;
      for (int k = 0; k < n; k++) begin
         w = rnd_word();
         a = ADDR_W'(ldb + k);
         wr_exp.push_back('{a, w});
         exp_mem[a] = w;
         s_valid = 1'b1; s_data = w; t = 0;
         while (!s_ready && t < 500) begin step(1); t++; end
         step(1);
         s_valid = 1'b0;
         step($urandom_range(0, 1));
      end
   endtask

   task automatic expect_reads(input int stb, input int n);
      for (int j = 0; j < n; j++) md_exp.push_back(exp_mem[ADDR_W'(stb + j)]);
   endtask

   task automatic wait_done(input int limit, output bit ok);
      int start = done_cnt;
      int t = 0;
      while (done_cnt == start && t < limit) begin step(1); t++; end
      ok = (done_cnt != start);
   endtask

   task automatic test_reset();
      rst = 1'b1; preload = 1'b1;
      step(2);
      preload = 1'b0;
      n_cmp++; if (cmd_ready !== 1'b1) begin n_mis++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
      n_cmp++; if (s_ready !== 1'b0) begin n_mis++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      n_cmp++; if (m_valid !== 1'b0) begin n_mis++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
      n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_mis++; $display("FAIL reset_done_err: got %b%b expected 00", done, err); end
      n_cmp++; if (core_run !== 1'b0 || core_extin_en !== 1'b0) begin n_mis++; $display("FAIL reset_run_en: got %b%b expected 00", core_run, core_extin_en); end
      n_cmp++; if (core_extin_addr !== '0 || core_extout_addr !== '0) begin n_mis++; $display("FAIL reset_addr: got %h/%h expected 0/0", core_extin_addr, core_extout_addr); end
      n_cmp++; if (core_n_func !== 4'h0) begin n_mis++; $display("FAIL reset_func: got %h expected 0", core_n_func); end
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_load_run();
      bit ok;
      int r0 = run_cnt;
      wr_t g, e;
      busy_delay = 3; busy_len = 5; never_busy = 1'b0;
      issue_cmd(4'h5, 'h010, 3, 0, 0);
      send_words('h010, 3);
      wait_done(300, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL load_done: got no done expected done within 300 cycles"); end
      for (int i = 0; wr_exp.size() > 0; i++) begin
         e = wr_exp.pop_front(); n_cmp++;
         if (wr_seen.size() == 0) begin n_mis++; $display("FAIL load_write%0d: got nothing expected addr %h", i, e.a); end
         else begin
            g = wr_seen.pop_front();
            if (g.a !== e.a || g.d !== e.d) begin n_mis++; $display("FAIL load_write%0d: got %h/%h expected %h/%h", i, g.a, g.d, e.a, e.d); end
         end
      end
      n_cmp++; if (wr_seen.size() != 0) begin n_mis++; $display("FAIL load_extra_writes: got %0d expected 0", wr_seen.size()); wr_seen.delete(); end
      n_cmp++; if (run_cnt - r0 != 1) begin n_mis++; $display("FAIL load_run_pulses: got %0d expected 1", run_cnt - r0); end
      n_cmp++; if (run_func !== 4'h5) begin n_mis++; $display("FAIL load_run_func: got %h expected 5", run_func); end
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL load_err: got %b expected 0", err); end
   endtask

   task automatic test_unload();
      bit ok;
      logic [DATA_W-1:0] g, e;
      busy_delay = 2; busy_len = 100; m_ready = 1'b1;
      issue_cmd(4'h9, 0, 0, 'h020, 4);
      expect_reads('h020, 4);
      wait_done(500, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL unload_done: got no done expected done within 500 cycles"); end
      for (int i = 0; md_exp.size() > 0; i++) begin
         e = md_exp.pop_front(); n_cmp++;
         if (md_seen.size() == 0) begin n_mis++; $display("FAIL unload_word%0d: got nothing expected %h", i, e); end
         else begin g = md_seen.pop_front(); if (g !== e) begin n_mis++; $display("FAIL unload_word%0d: got %h expected %h", i, g, e); end end
      end
      n_cmp++; if (md_seen.size() != 0) begin n_mis++; $display("FAIL unload_extra: got %0d words expected 0", md_seen.size()); md_seen.delete(); end
      n_cmp++; if (done_cyc != beat_cyc + 1) begin n_mis++; $display("FAIL unload_done_timing: got cycle %0d expected %0d", done_cyc, beat_cyc + 1); end
      n_cmp++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin n_mis++; $display("FAIL unload_after: got done=%b cmd_ready=%b expected 0/1", done, cmd_ready); end
      n_cmp++; if (run_func !== 4'h9) begin n_mis++; $display("FAIL unload_func: got %h expected 9", run_func); end
   endtask

   task automatic test_backpressure();
      bit ok, unstable;
      int f0, t;
      logic [DATA_W-1:0] held, g, e;
      logic [ADDR_W-1:0] issued;
      busy_delay = 2; busy_len = 10; m_ready = 1'b0;
      issue_cmd(4'h2, 'h100, 8, 'h100, 8);
      f0 = fall_cyc;
      send_words('h100, 8);
      expect_reads('h100, 8);
      t = 0;
      while (fall_cyc == f0 && t < 300) begin step(1); t++; end
      unstable = 1'b0; held = '0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (m_valid && held === '0) held = m_data;
         else if (m_valid && m_data !== held) unstable = 1'b1;
      end
      issued = core_extout_addr - ADDR_W'('h100);
      n_cmp++; if (issued > ADDR_W'(RD_LAT + 2) || issued == '0) begin n_mis++; $display("FAIL stall_reads_issued: got %0d expected 1..%0d", issued, RD_LAT + 2); end
      n_cmp++; if (m_valid !== 1'b1) begin n_mis++; $display("FAIL stall_m_valid: got %b expected 1", m_valid); end
      n_cmp++; if (unstable) begin n_mis++; $display("FAIL stall_m_data_stable: got changing data expected stable %h", held); end
      m_ready = 1'b1;
      wait_done(300, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL stall_done: got no done expected done within 300 cycles"); end
      for (int i = 0; md_exp.size() > 0; i++) begin
         e = md_exp.pop_front(); n_cmp++;
         if (md_seen.size() == 0) begin n_mis++; $display("FAIL stall_word%0d: got nothing expected %h", i, e); end
         else begin g = md_seen.pop_front(); if (g !== e) begin n_mis++; $display("FAIL stall_word%0d: got %h expected %h", i, g, e); end end
      end
      n_cmp++; if (md_seen.size() != 0) begin n_mis++; $display("FAIL stall_extra: got %0d words expected 0", md_seen.size()); md_seen.delete(); end
      wr_exp.delete(); wr_seen.delete();
   endtask

   task automatic test_timeout();
      bit ok;
      int mv0 = mvalid_cyc;
      never_busy = 1'b1;
      issue_cmd(4'h3, 0, 0, 'h040, 2);
      wait_done(300, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL timeout_done: got no done expected done"); end
      n_cmp++; if (done_cyc - run_cyc != START_TO) begin n_mis++; $display("FAIL timeout_latency: got %0d expected %0d", done_cyc - run_cyc, START_TO); end
      n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL timeout_err: got %b expected 1", err); end
      n_cmp++; if (mvalid_cyc != mv0) begin n_mis++; $display("FAIL timeout_no_unload: got %0d m_valid cycles expected 0", mvalid_cyc - mv0); end
      never_busy = 1'b0; busy_delay = 1; busy_len = 3;
      issue_cmd(4'h2, 0, 0, 0, 0);
      n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL timeout_err_clear: got %b expected 0", err); end
      wait_done(200, ok);
      n_cmp++; if (!ok || err !== 1'b0) begin n_mis++; $display("FAIL timeout_recover: got ok=%b err=%b expected 1/0", ok, err); end
   endtask

   task automatic test_zero_len();
      bit ok;
      int sr0 = sready_cyc;
      int mv0 = mvalid_cyc;
      busy_delay = 2; busy_len = 6;
      issue_cmd(4'h7, 'h050, 0, 'h060, 0);
      wait_done(200, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL zero_done: got no done expected done"); end
      n_cmp++; if (run_cyc != accept_cyc + 1) begin n_mis++; $display("FAIL zero_run_timing: got cycle %0d expected %0d", run_cyc, accept_cyc + 1); end
      n_cmp++; if (done_cyc != fall_cyc) begin n_mis++; $display("FAIL zero_done_on_fall: got cycle %0d expected %0d", done_cyc, fall_cyc); end
      n_cmp++; if (sready_cyc != sr0 || mvalid_cyc != mv0) begin n_mis++; $display("FAIL zero_no_stream: got %0d/%0d cycles expected 0/0", sready_cyc - sr0, mvalid_cyc - mv0); end
      n_cmp++; if (run_func !== 4'h7) begin n_mis++; $display("FAIL zero_func: got %h expected 7", run_func); end
   endtask

   task automatic test_back_to_back();
      bit ok1, ok2;
      wr_t g, e;
      logic [DATA_W-1:0] gw, ew;
      busy_delay = 1; busy_len = 4; rand_ready = 1'b1;
      issue_cmd(4'h1, 'h3FE, 4, 'h3FF, 3);
      send_words('h3FE, 4);
      expect_reads('h3FF, 3);
      wait_done(400, ok1);
      issue_cmd(4'hC, 'h005, 2, 'h3FE, 2);
      send_words('h005, 2);
      expect_reads('h3FE, 2);
      wait_done(400, ok2);
      rand_ready = 1'b0; m_ready = 1'b1;
      n_cmp++; if (!(ok1 && ok2)) begin n_mis++; $display("FAIL b2b_done: got %b%b expected 11", ok1, ok2); end
      for (int i = 0; wr_exp.size() > 0; i++) begin
         e = wr_exp.pop_front(); n_cmp++;
         if (wr_seen.size() == 0) begin n_mis++; $display("FAIL b2b_write%0d: got nothing expected addr %h", i, e.a); end
         else begin
            g = wr_seen.pop_front();
            if (g.a !== e.a || g.d !== e.d) begin n_mis++; $display("FAIL b2b_write%0d: got %h/%h expected %h/%h", i, g.a, g.d, e.a, e.d); end
         end
      end
      for (int i = 0; md_exp.size() > 0; i++) begin
         ew = md_exp.pop_front(); n_cmp++;
         if (md_seen.size() == 0) begin n_mis++; $display("FAIL b2b_word%0d: got nothing expected %h", i, ew); end
         else begin gw = md_seen.pop_front(); if (gw !== ew) begin n_mis++; $display("FAIL b2b_word%0d: got %h expected %h", i, gw, ew); end end
      end
      n_cmp++; if (md_seen.size() != 0 || wr_seen.size() != 0) begin n_mis++; $display("FAIL b2b_extra: got %0d/%0d expected 0/0", md_seen.size(), wr_seen.size()); md_seen.delete(); wr_seen.delete(); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int f0, t;
      logic [DATA_W-1:0] g, e;
      busy_delay = 2; busy_len = 5; m_ready = 1'b0;
      issue_cmd(4'h6, 0, 0, 'h200, 8);
      f0 = fall_cyc; t = 0;
      while (fall_cyc == f0 && t < 300) begin step(1); t++; end
      step(15);
      n_cmp++; if (m_valid !== 1'b1) begin n_mis++; $display("FAIL rstmid_pre_valid: got %b expected 1", m_valid); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (m_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_mis++; $display("FAIL rstmid_immediate: got m_valid=%b cmd_ready=%b expected 0/1", m_valid, cmd_ready); end
      step(2);
      rst = 1'b0;
      step(4);
      n_cmp++; if (m_valid !== 1'b0 || cmd_ready !== 1'b1) begin n_mis++; $display("FAIL rstmid_after: got m_valid=%b cmd_ready=%b expected 0/1", m_valid, cmd_ready); end
      md_seen.delete();
      busy_delay = 1; busy_len = 3; m_ready = 1'b1;
      issue_cmd(4'h1, 0, 0, 'h300, 2);
      expect_reads('h300, 2);
      wait_done(300, ok);
      n_cmp++; if (!ok) begin n_mis++; $display("FAIL rstmid_recover_done: got no done expected done"); end
      for (int i = 0; md_exp.size() > 0; i++) begin
         e = md_exp.pop_front(); n_cmp++;
         if (md_seen.size() == 0) begin n_mis++; $display("FAIL rstmid_word%0d: got nothing expected %h", i, e); end
         else begin g = md_seen.pop_front(); if (g !== e) begin n_mis++; $display("FAIL rstmid_word%0d: got %h expected %h", i, g, e); end end
      end
      n_cmp++; if (md_seen.size() != 0) begin n_mis++; $display("FAIL rstmid_extra: got %0d words expected 0", md_seen.size()); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_func = '0;
      cmd_ld_base = '0; cmd_ld_len = '0; cmd_st_base = '0; cmd_st_len = '0;
      s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
      for (int i = 0; i < MEM_N; i++) exp_mem[i] = pat(i);
      test_reset();
      test_load_run();
      test_unload();
      test_backpressure();
      test_timeout();
      test_zero_len();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
